// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding mux select codes and the per-stage
// destination-register metadata record carried by the hazard shadow pipeline.
package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             rw;
    logic             mr;
  } stage_meta_t;

  localparam stage_meta_t META_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding comparator: picks MEM, WB or register-file source for one
// ALU operand from the producer metadata sitting in the MEM and WB stages.
module fwd_sel #(
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_rw,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_rw,
  output logic [1:0]       sel
);
  import cpu_pkg::*;

  logic mem_hit;
  logic wb_hit;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign mem_hit = mem_rw && (mem_dest != '0) && (mem_dest == src);
  assign wb_hit  = wb_rw  && (wb_dest  != '0) && (wb_dest  == src);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves sel unassigned (no latch).
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Forwarding and load-use hazard controller: shadows EX/MEM/WB destination
// metadata, drives operand mux selects, and stalls one cycle on load-use.
module fwd_ctrl_unit #(
  parameter int REG_W = cpu_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);
  import cpu_pkg::*;

  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  stage_meta_t      ex_meta;
  stage_meta_t      mem_meta;
  stage_meta_t      wb_meta;
  logic             bubble;

  // A load in EX whose result the ID instruction needs cannot be forwarded in
  // time; a taken branch discards that consumer anyway, so flush suppresses it.
  assign stall = !flush && ex_meta.mr && (ex_meta.dest != '0) &&
                 ((ex_meta.dest == id_rs) || (ex_meta.dest == id_rt));

  assign bubble = stall || flush;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all stages advance from the same pre-edge values.
    if (!rst_n) begin
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_meta  <= META_BUBBLE;
      mem_meta <= META_BUBBLE;
      wb_meta  <= META_BUBBLE;
    end else begin
      if (bubble) begin
        ex_rs   <= '0;
        ex_rt   <= '0;
        ex_meta <= META_BUBBLE;
      end else begin
        ex_rs   <= id_rs;
        ex_rt   <= id_rt;
        ex_meta <= '{dest: id_dest, rw: id_reg_write, mr: id_mem_read};
      end
      mem_meta <= ex_meta;
      wb_meta  <= mem_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src      (ex_rs),
    .mem_dest (mem_meta.dest),
    .mem_rw   (mem_meta.rw),
    .wb_dest  (wb_meta.dest),
    .wb_rw    (wb_meta.rw),
    .sel      (fwd_a)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src      (ex_rt),
    .mem_dest (mem_meta.dest),
    .mem_rw   (mem_meta.rw),
    .wb_dest  (wb_meta.dest),
    .wb_rw    (wb_meta.rw),
    .sel      (fwd_b)
  );

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Self-checking bench for fwd_ctrl_unit: a table of per-cycle ID inputs with
// expected selects/stall/count, plus saturation and asynchronous-reset sequences.
module tb_fwd_ctrl_unit;

  localparam int REG_W     = 5;
  localparam int CNT_W     = 16;
  localparam int SAT_W     = 2;
  localparam int NUM_ROWS  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs, id_rt, id_dest;
  logic             id_reg_write, id_mem_read, flush;
  logic [1:0]       fwd_a, fwd_b, sat_fwd_a, sat_fwd_b;
  logic             stall, sat_stall;
  logic [CNT_W-1:0] stall_cnt;
  logic [SAT_W-1:0] sat_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [REG_W-1:0] rs, rt, dest;
    logic             rw, mr, fl;
    logic [1:0]       ea, eb;
    logic             es;
    int               ec;
  } vec_t;

  typedef struct {
    logic [1:0] ea, eb;
    logic       es;
    int         ec;
    string      tag;
  } exp_t;

  vec_t vecs [NUM_ROWS];
  exp_t sb [$];

  always #5 clk = ~clk;

  fwd_ctrl_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, used to reach saturation quickly.
  fwd_ctrl_unit #(.REG_W(REG_W), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a(sat_fwd_a), .fwd_b(sat_fwd_b), .stall(sat_stall), .stall_cnt(sat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int rs, rt, dest, rw, mr, fl, ea, eb, es, ec);
    vec_t v;
    v.rs = REG_W'(rs); v.rt = REG_W'(rt); v.dest = REG_W'(dest);
    v.rw = 1'(rw); v.mr = 1'(mr); v.fl = 1'(fl);
    v.ea = 2'(ea); v.eb = 2'(eb); v.es = 1'(es); v.ec = ec;
    return v;
  endfunction

  // One cycle: drive ID after the edge, queue the expectation, compare at the falling edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    int   sat_exp;
    @(posedge clk);
    #1;
    id_rs = v.rs; id_rt = v.rt; id_dest = v.dest;
    id_reg_write = v.rw; id_mem_read = v.mr; flush = v.fl;
    e.ea = v.ea; e.eb = v.eb; e.es = v.es; e.ec = v.ec; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    sat_exp = (e.ec > 3) ? 3 : e.ec;
    check({e.tag, " fwd_a"},     32'(fwd_a),     32'(e.ea));
    check({e.tag, " fwd_b"},     32'(fwd_b),     32'(e.eb));
    check({e.tag, " stall"},     32'(stall),     32'(e.es));
    check({e.tag, " stall_cnt"}, 32'(stall_cnt), 32'(e.ec));
    check({e.tag, " sat_cnt"},   32'(sat_cnt),   32'(sat_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              rs rt dst rw mr fl  ea eb es cnt
    vecs[0]  = mk(1, 2, 3,  1, 0, 0, 0, 0, 0, 0);  // add $3
    vecs[1]  = mk(3, 4, 10, 1, 0, 0, 0, 0, 0, 0);  // sub rs=$3 rt=$4
    vecs[2]  = mk(0, 0, 0,  0, 0, 0, 2, 0, 0, 0);  // sub in EX: MEM forward on A
    vecs[3]  = mk(1, 1, 5,  1, 0, 0, 0, 0, 0, 0);  // add $5
    vecs[4]  = mk(1, 2, 11, 1, 0, 0, 0, 0, 0, 0);  // independent
    vecs[5]  = mk(6, 5, 12, 1, 0, 0, 0, 0, 0, 0);  // or rs=$6 rt=$5
    vecs[6]  = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 0);  // or in EX: WB forward on B
    vecs[7]  = mk(1, 2, 7,  1, 0, 0, 0, 0, 0, 0);  // add $7
    vecs[8]  = mk(1, 2, 7,  1, 0, 0, 0, 0, 0, 0);  // add $7 again
    vecs[9]  = mk(7, 3, 13, 1, 0, 0, 0, 0, 0, 0);  // and rs=$7
    vecs[10] = mk(0, 0, 0,  0, 0, 0, 2, 0, 0, 0);  // MEM beats WB
    vecs[11] = mk(1, 0, 8,  1, 1, 0, 0, 0, 0, 0);  // lw $8
    vecs[12] = mk(8, 2, 14, 1, 0, 0, 0, 0, 1, 0);  // add rs=$8: load-use stall
    vecs[13] = mk(8, 2, 14, 1, 0, 0, 0, 0, 0, 1);  // held in ID, bubble in EX
    vecs[14] = mk(0, 0, 0,  0, 0, 0, 1, 0, 0, 1);  // add in EX, load in WB
    vecs[15] = mk(1, 0, 9,  1, 1, 0, 0, 0, 0, 1);  // lw $9
    vecs[16] = mk(9, 9, 15, 1, 0, 1, 0, 0, 0, 1);  // dependent but flushed
    vecs[17] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1);  // bubble in EX
    vecs[18] = mk(1, 2, 0,  1, 0, 0, 0, 0, 0, 1);  // write $0
    vecs[19] = mk(0, 0, 16, 1, 0, 0, 0, 0, 0, 1);  // read $0
    vecs[20] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1);  // $0 never forwarded
    vecs[21] = mk(1, 2, 0,  1, 1, 0, 0, 0, 0, 1);  // lw $0
    vecs[22] = mk(0, 3, 17, 1, 0, 0, 0, 0, 0, 1);  // reader of $0: no stall
    vecs[23] = mk(1, 0, 20, 1, 1, 0, 0, 0, 0, 1);  // lw $20
    vecs[24] = mk(20, 0, 21, 1, 1, 0, 0, 0, 1, 1); // lw $21 uses $20: stall
    vecs[25] = mk(20, 0, 21, 1, 1, 0, 0, 0, 0, 2);
    vecs[26] = mk(4, 21, 22, 1, 0, 0, 1, 0, 1, 2); // add uses $21: stall again
    vecs[27] = mk(4, 21, 22, 1, 0, 0, 0, 0, 0, 3);
    vecs[28] = mk(0, 0, 0,  0, 0, 0, 0, 1, 0, 3);
    vecs[29] = mk(1, 2, 23, 1, 0, 0, 0, 0, 0, 3);  // add $23
    vecs[30] = mk(23, 23, 24, 1, 0, 0, 0, 0, 0, 3);// sub rs=rt=$23
    vecs[31] = mk(0, 0, 0,  0, 0, 0, 2, 2, 0, 3);  // MEM forward on both

    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_dest = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    check("reset fwd_a",     32'(fwd_a),     32'd0);
    check("reset fwd_b",     32'(fwd_b),     32'd0);
    check("reset stall",     32'(stall),     32'd0);
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);

    for (int i = 0; i < NUM_ROWS; i++) begin
      step(vecs[i], $sformatf("row%0d", i));
    end

    // Fourth load-use pair: the 16-bit counter reaches 4, the 2-bit copy holds at 3.
    step(mk(1, 0, 25, 1, 1, 0, 0, 0, 0, 3), "sat0");
    step(mk(25, 0, 26, 1, 0, 0, 0, 0, 1, 3), "sat1");
    step(mk(25, 0, 26, 1, 0, 0, 0, 0, 0, 4), "sat2");

    // Build live state (stall high, MEM forward pending), then reset between edges.
    step(mk(26, 0, 27, 1, 1, 0, 1, 0, 0, 4), "rst0");
    step(mk(27, 0, 28, 1, 0, 0, 2, 0, 1, 4), "rst1");
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst fwd_a",     32'(fwd_a),     32'd0);
    check("async rst fwd_b",     32'(fwd_b),     32'd0);
    check("async rst stall",     32'(stall),     32'd0);
    check("async rst stall_cnt", 32'(stall_cnt), 32'd0);
    check("async rst sat_cnt",   32'(sat_cnt),   32'd0);
    #1;
    rst_n = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
